// File: rtl/in3072_out1536.sv
// rtl/in3072_out1536.sv - wide-to-narrow AXI-Stream width down-converter
// One wide beat is held and replayed as RATIO narrow beats, lowest sub-word first.
module in3072_out1536 #(
  parameter int IN_WIDTH  = 3072,
  parameter int OUT_WIDTH = 1536
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IN_WIDTH-1:0]           s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [IN_WIDTH/OUT_WIDTH-1:0] s_axis_tlast,
  input  logic                          weight_switch,
  output logic [OUT_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          weight_switch_out
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;

  logic [IN_WIDTH-1:0] r_hold_data;
  logic [RATIO-1:0]    r_hold_last;
  logic                r_hold_ws;
  logic                r_hold_valid;
  logic [CNT_W-1:0]    r_idx;
  logic                r_ws_out;

  logic w_last_sub;
  logic w_out_fire;
  logic w_load;

  assign m_axis_tvalid     = r_hold_valid;
  assign m_axis_tdata      = r_hold_data[int'(r_idx)*OUT_WIDTH +: OUT_WIDTH];
  assign m_axis_tlast      = r_hold_last[r_idx];
  assign weight_switch_out = r_ws_out;

  // A set tlast bit ends the word early; later sub-words are never replayed.
  assign w_last_sub    = (r_idx == CNT_W'(RATIO - 1)) | r_hold_last[r_idx];
  assign w_out_fire    = r_hold_valid & m_axis_tready;
  assign s_axis_tready = ~r_hold_valid | (w_out_fire & w_last_sub);
  assign w_load        = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data  <= '0;
      r_hold_last  <= '0;
      r_hold_ws    <= 1'b0;
      r_hold_valid <= 1'b0;
      r_idx        <= '0;
      r_ws_out     <= 1'b0;
    end else begin
      r_ws_out <= w_out_fire & m_axis_tlast & r_hold_ws;
      if (w_load) begin
        r_hold_data  <= s_axis_tdata;
        r_hold_last  <= s_axis_tlast;
        r_hold_ws    <= weight_switch;
        r_hold_valid <= 1'b1;
        r_idx        <= '0;
      end else if (w_out_fire) begin
        if (w_last_sub) begin
          r_hold_valid <= 1'b0;
          r_idx        <= '0;
        end else begin
          r_idx <= r_idx + CNT_W'(1);
        end
      end
    end
  end

endmodule
